// File: rtl/coffee_pkg.sv
// Shared types and constants for the COFFEE front-panel controls.
// Run states are also the LED encoding exported on button_ctl.state.
package coffee_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HALT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_STEP  = 2'd3
    } run_state_t;

    localparam int BTN_RUN  = 0;
    localparam int BTN_RST  = 1;
    localparam int BTN_STEP = 2;
    localparam int NUM_BTN  = 3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce.sv
// One active-low push button: 2-FF synchroniser, debounce counter and a
// registered single-cycle press pulse on each accepted 1->0 transition.
module debounce
    import coffee_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            stable_reg <= 1'b1;
            press_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Level held long enough: accept it; only a press is an event.
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
                press_reg  <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/button_ctl.sv
// Front-panel run control: debounced buttons drive a RESET/HALT/RUN/STEP
// machine that produces the CPU/MMU reset and the halt (stall) request.
module button_ctl
    import coffee_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_HOLD        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] button,
    output logic       cpuRstN,
    output logic       haltReq,
    output logic [1:0] state
);

    localparam int HW = cnt_width(RST_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    logic [NUM_BTN-1:0] press;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .btn_n(button[gi]),
                .press(press[gi])
            );
        end
    endgenerate

    run_state_t    state_reg,    state_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          hold_arm_reg, hold_arm_next;
    logic          cpu_rst_n_reg, cpu_rst_n_next;
    logic          halt_req_reg,  halt_req_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RESET;
            hold_cnt_reg  <= '0;
            hold_arm_reg  <= 1'b0;
            cpu_rst_n_reg <= 1'b0;
            halt_req_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            hold_arm_reg  <= hold_arm_next;
            cpu_rst_n_reg <= cpu_rst_n_next;
            halt_req_reg  <= halt_req_next;
        end
    end

    // The first edge after rst release acts as the RESET entry edge, so the
    // hold length matches a press-initiated reset (hold_arm gates counting).
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = '0;
        hold_arm_next = 1'b1;

        if (press[BTN_RST]) begin
            state_next = ST_RESET;
        end else begin
            unique case (state_reg)
                ST_RESET: begin
                    if (!hold_arm_reg) begin
                        hold_cnt_next = '0;
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        state_next = ST_HALT;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                end
                ST_HALT: begin
                    if (press[BTN_RUN]) begin
                        state_next = ST_RUN;
                    end else if (press[BTN_STEP]) begin
                        state_next = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (press[BTN_RUN]) begin
                        state_next = ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_next = ST_HALT;
                end
                default: begin
                    state_next = ST_RESET;
                end
            endcase
        end

        cpu_rst_n_next = (state_next != ST_RESET);
        halt_req_next  = (state_next == ST_RESET) || (state_next == ST_HALT);
    end

    assign cpuRstN = cpu_rst_n_reg;
    assign haltReq = halt_req_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_button_ctl.sv
// Scenario bench for button_ctl with DEBOUNCE_CYCLES=4, RST_HOLD=3: per-cycle
// expected {cpuRstN, haltReq, state} values are queued, then checked each negedge.
module tb_button_ctl;

    localparam logic [3:0] O_RESET = 4'b0100;  // cpuRstN=0 haltReq=1 state=0
    localparam logic [3:0] O_HALT  = 4'b1101;  // cpuRstN=1 haltReq=1 state=1
    localparam logic [3:0] O_RUN   = 4'b1010;  // cpuRstN=1 haltReq=0 state=2
    localparam logic [3:0] O_STEP  = 4'b1011;  // cpuRstN=1 haltReq=0 state=3

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] button;
    logic       cpuRstN;
    logic       haltReq;
    logic [1:0] state;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    button_ctl #(
        .DEBOUNCE_CYCLES(4),
        .RST_HOLD       (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .cpuRstN(cpuRstN),
        .haltReq(haltReq),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] val, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = tag;
            e.val = val;
            exp_q.push_back(e);
        end
    endtask

    // Hold the buttons at btn for n cycles, checking one queued value per cycle.
    task automatic run(input string name, input int n, input logic [2:0] btn);
        exp_t e;
        $display("[TB] %s: button=%b for %0d cycles", name, btn, n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            button = btn;
            if (exp_q.size() == 0) begin
                chk({name, "_sb_underflow"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk(e.tag, {28'd0, cpuRstN, haltReq, state}, {28'd0, e.val});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        button = 3'b111;
        repeat (2) @(negedge clk);
        chk("reset_state", {28'd0, cpuRstN, haltReq, state}, {28'd0, O_RESET});

        // Reset release: cpuRstN low three cycles, then HALT.
        rst = 1'b0;
        push("rel_hold", O_RESET, 3);
        push("rel_halt", O_HALT, 1);
        run("reset_release", 4, 3'b111);

        // Bounce shorter than the debounce window.
        push("bounce", O_HALT, 14);
        run("bounce_lo3", 3, 3'b110);
        run("bounce_hi1", 1, 3'b111);
        run("bounce_lo2", 2, 3'b110);
        run("bounce_hi", 8, 3'b111);

        // Run toggle: haltReq drops exactly 7 cycles after the press.
        push("run_wait", O_HALT, 7);
        push("run_on", O_RUN, 3);
        run("run_press", 10, 3'b110);
        push("run_rel", O_RUN, 8);
        run("run_release", 8, 3'b111);
        push("halt_wait", O_RUN, 7);
        push("halt_on", O_HALT, 3);
        run("halt_press", 10, 3'b110);
        push("halt_rel", O_HALT, 8);
        run("halt_release", 8, 3'b111);

        // Single step from HALT.
        push("step_wait", O_HALT, 7);
        push("step_one", O_STEP, 1);
        push("step_back", O_HALT, 2);
        run("step_press", 10, 3'b011);
        push("step_rel", O_HALT, 8);
        run("step_release", 8, 3'b111);

        // Step ignored in RUN.
        push("run2_wait", O_HALT, 7);
        push("run2_on", O_RUN, 3);
        run("run2_press", 10, 3'b110);
        push("run2_rel", O_RUN, 8);
        run("run2_release", 8, 3'b111);
        push("step_in_run", O_RUN, 18);
        run("step_in_run_press", 10, 3'b011);
        run("step_in_run_release", 8, 3'b111);

        // Reset beats run when pressed together.
        push("prio_wait", O_RUN, 7);
        push("prio_rst", O_RESET, 3);
        run("prio_press", 10, 3'b100);
        push("prio_halt", O_HALT, 8);
        run("prio_release", 8, 3'b111);

        // Async rst in the middle of a RESET hold count restarts it.
        push("mid_hold_wait", O_HALT, 7);
        push("mid_hold_rst", O_RESET, 2);
        run("mid_hold_press", 9, 3'b101);
        rst    = 1'b1;
        button = 3'b111;
        #1;
        chk("mid_hold_async", {28'd0, cpuRstN, haltReq, state}, {28'd0, O_RESET});
        push("mid_hold_in_rst", O_RESET, 2);
        run("mid_hold_rst_held", 2, 3'b111);
        rst = 1'b0;
        push("mid_hold_rehold", O_RESET, 3);
        push("mid_hold_halt", O_HALT, 1);
        run("mid_hold_release", 4, 3'b111);

        // Async rst in the middle of a debounce: held button re-debounces fully.
        push("mid_db_wait", O_HALT, 5);
        run("mid_db_press", 5, 3'b110);
        rst = 1'b1;
        #1;
        chk("mid_db_async", {28'd0, cpuRstN, haltReq, state}, {28'd0, O_RESET});
        push("mid_db_in_rst", O_RESET, 2);
        run("mid_db_rst_held", 2, 3'b110);
        rst = 1'b0;
        push("mid_db_hold", O_RESET, 3);
        push("mid_db_halt", O_HALT, 3);
        push("mid_db_run", O_RUN, 4);
        run("mid_db_held", 10, 3'b110);
        push("mid_db_rel", O_RUN, 8);
        run("mid_db_release", 8, 3'b111);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
